fft_bar_reader: RTL and testbench

Sequential consumer of the 16-bin complex spectrum produced by the FFT processor. On a frame handshake it captures all sixteen 32-bit bins, computes an approximate magnitude per bin, and converts it to a 4-bit bar level with per-bin peak-hold decay. It streams the results one bin at a time over a valid/ready interface to the display driver of the audio visualizer.

---
 rtl/fft_bar_reader.sv | 128 ++++++++++++
 tb/tb_fft_bar_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bar_reader.sv
// fft_bar_reader: captures a 16-bin spectrum, converts each bin to a peak-held
// 4-bit bar level and streams the results over valid/ready.
module fft_bar_reader #(
  parameter int LEVEL_SHIFT = 11,
  parameter int DECAY_STEP  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] f0,
  input  logic [31:0] f1,
  input  logic [31:0] f2,
  input  logic [31:0] f3,
  input  logic [31:0] f4,
  input  logic [31:0] f5,
  input  logic [31:0] f6,
  input  logic [31:0] f7,
  input  logic [31:0] f8,
  input  logic [31:0] f9,
  input  logic [31:0] f10,
  input  logic [31:0] f11,
  input  logic [31:0] f12,
  input  logic [31:0] f13,
  input  logic [31:0] f14,
  input  logic [31:0] f15,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        bar_valid,
  input  logic        bar_ready,
  output logic [3:0]  bar_idx,
  output logic [3:0]  bar_level,
  output logic        frame_done
);
  typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] f_in [16];
  logic [31:0] bins_q [16];
  logic [31:0] bins_d [16];
  logic [3:0]  peak_q [16];
  logic [3:0]  peak_d [16];
  logic [3:0]  k_q, k_d, idx_q, idx_d, level_q, level_d;
  logic        valid_q, valid_d, done_q, done_d;
  logic [14:0] abs_re, abs_im, mx, mn;
  logic [16:0] mag, lvl_wide;
  logic [3:0]  lvl, pk, new_pk;

  // 0x8000 has no positive 16-bit counterpart, so it saturates to 32767
  function automatic logic [14:0] abs_sat(input logic [15:0] x);
    return x[15] ? ((x == 16'h8000) ? 15'h7fff : 15'(-x)) : x[14:0];
  endfunction

  assign f_in = '{f0, f1, f2, f3, f4, f5, f6, f7, f8, f9, f10, f11, f12, f13, f14, f15};

  always_comb begin
    abs_re   = abs_sat(bins_q[k_q][31:16]);
    abs_im   = abs_sat(bins_q[k_q][15:0]);
    mx       = (abs_re >= abs_im) ? abs_re : abs_im;
    mn       = (abs_re >= abs_im) ? abs_im : abs_re;
    mag      = 17'(mx) + 17'(mn >> 1);
    lvl_wide = mag >> LEVEL_SHIFT;
    lvl      = (lvl_wide > 17'd15) ? 4'd15 : lvl_wide[3:0];
    pk       = peak_q[k_q];
    // decay never undershoots the fresh level, which also keeps it at or above 0
    new_pk   = (lvl >= pk) ? lvl :
               (5'(pk) > 5'(lvl) + 5'(DECAY_STEP)) ? pk - 4'(DECAY_STEP) : lvl;
  end

  always_comb begin
    state_d = state_q;
    bins_d  = bins_q;
    peak_d  = peak_q;
    k_d     = k_q;
    idx_d   = idx_q;
    level_d = level_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (frame_valid) begin
        bins_d  = f_in;
        k_d     = 4'd0;
        state_d = CALC;
      end
      CALC: begin
        peak_d[k_q] = new_pk;
        idx_d       = k_q;
        level_d     = new_pk;
        valid_d     = 1'b1;
        state_d     = EMIT;
      end
      EMIT: if (bar_ready) begin
        valid_d = 1'b0;
        done_d  = (k_q == 4'd15);
        k_d     = (k_q == 4'd15) ? k_q : k_q + 4'd1;
        state_d = (k_q == 4'd15) ? DONE : CALC;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        bins_q[i] <= '0;
        peak_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      bins_q  <= bins_d;
      peak_q  <= peak_d;
    end
  end

  assign frame_ready = (state_q == IDLE);
  assign bar_valid   = valid_q;
  assign bar_idx     = idx_q;
  assign bar_level   = level_q;
  assign frame_done  = done_q;
endmodule

// File: tb/tb_fft_bar_reader.sv
// tb_fft_bar_reader: random and directed frames checked every cycle against a
// frame-level model of bar levels, peak hold and handshake timing.
module tb_fft_bar_reader;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [31:0] fb [16];
  logic        frame_valid = 0;
  logic        bar_ready = 1;
  logic        frame_ready, bar_valid, frame_done;
  logic [3:0]  bar_idx, bar_level;

  int n_pass = 0, n_total = 0;
  int cycle = 0, cap_edge = 0, done_edge = 0, cap_cnt = 0, done_cnt = 0, got_cnt = 0;
  int got_level [16];
  int mpeak [16];
  int exp_idx [$];
  int exp_lvl [$];
  bit busy = 0, calc = 0, done_now = 0;

  fft_bar_reader dut (
    .clk(clk), .reset_n(reset_n),
    .f0(fb[0]), .f1(fb[1]), .f2(fb[2]), .f3(fb[3]),
    .f4(fb[4]), .f5(fb[5]), .f6(fb[6]), .f7(fb[7]),
    .f8(fb[8]), .f9(fb[9]), .f10(fb[10]), .f11(fb[11]),
    .f12(fb[12]), .f13(fb[13]), .f14(fb[14]), .f15(fb[15]),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .bar_valid(bar_valid), .bar_ready(bar_ready),
    .bar_idx(bar_idx), .bar_level(bar_level), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cycle);
  endtask

  function automatic int lvl_of(input logic [31:0] b);
    int re, im, a, c, m;
    re = int'(signed'(b[31:16]));
    im = int'(signed'(b[15:0]));
    a = (re < 0) ? -re : re;
    c = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (c > 32767) c = 32767;
    m = ((a > c) ? a : c) + ((a > c) ? c : a) / 2;
    m = m / 2048;
    return (m > 15) ? 15 : m;
  endfunction

  function automatic logic [31:0] rnd_bin();
    logic signed [15:0] a, b;
    a = 16'($urandom) >>> $urandom_range(0, 15);
    b = 16'($urandom) >>> $urandom_range(0, 15);
    return {a, b};
  endfunction

  always @(negedge clk) begin : mon
    bit v_exp, cap, acc;
    int l;
    if (!reset_n) begin
      check("rst_frame_ready", int'(frame_ready), 1);
      check("rst_bar_valid", int'(bar_valid), 0);
      check("rst_frame_done", int'(frame_done), 0);
      busy = 0; calc = 0; done_now = 0;
      exp_idx.delete(); exp_lvl.delete();
      for (int i = 0; i < 16; i++) mpeak[i] = 0;
    end else begin
      v_exp = busy && !calc && !done_now && exp_idx.size() > 0;
      check("frame_ready", int'(frame_ready), int'(!busy));
      check("frame_done", int'(frame_done), int'(done_now));
      check("bar_valid", int'(bar_valid), int'(v_exp));
      if (v_exp) begin
        check("bar_idx", int'(bar_idx), exp_idx[0]);
        check("bar_level", int'(bar_level), exp_lvl[0]);
      end
      if (frame_done) begin
        done_edge = cycle;
        done_cnt++;
      end
      cap = frame_valid && !busy;
      acc = v_exp && bar_ready;
      if (cap) begin
        busy = 1; calc = 1;
        cap_edge = cycle + 1;
        cap_cnt++;
        got_cnt = 0;
        for (int i = 0; i < 16; i++) begin
          l = lvl_of(fb[i]);
          mpeak[i] = (l >= mpeak[i]) ? l : ((mpeak[i] - 1 > l) ? mpeak[i] - 1 : l);
          exp_idx.push_back(i);
          exp_lvl.push_back(mpeak[i]);
        end
      end else if (acc) begin
        got_level[bar_idx] = int'(bar_level);
        got_cnt++;
        void'(exp_idx.pop_front());
        void'(exp_lvl.pop_front());
        if (exp_idx.size() == 0) begin
          done_now = 1; calc = 0;
        end else calc = 1;
      end else begin
        if (done_now) begin
          done_now = 0; busy = 0;
        end
        calc = 0;
      end
    end
  end

  task automatic send_frame(input logic [31:0] d [16]);
    int c0 = cap_cnt;
    for (int i = 0; i < 16; i++) fb[i] = d[i];
    frame_valid = 1;
    for (int i = 0; i < 200 && cap_cnt == c0; i++) begin
      @(posedge clk); #1;
    end
    if (cap_cnt == c0) check("capture_timeout", 0, 1);
    frame_valid = 0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_bin(input int k);
    for (int i = 0; i < 200 && !(bar_valid && int'(bar_idx) == k); i++) begin
      @(posedge clk); #1;
    end
    if (!(bar_valid && int'(bar_idx) == k)) check("bin_timeout", int'(bar_idx), k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] fr [16];
    int d0;
    fr = '{default: '0};
    for (int i = 0; i < 16; i++) fb[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;

    fr[3] = 32'h4000_0000;
    send_frame(fr); wait_done();
    check("f1_bin3", got_level[3], 8);
    for (int i = 0; i < 16; i++) if (i != 3) check("f1_other_bin", got_level[i], 0);
    check("f1_latency", done_edge - cap_edge, 32);
    check("f1_count", got_cnt, 16);
    check("f1_done_once", done_cnt, 1);

    fr[3] = '0; fr[5] = 32'h8000_8000; fr[6] = 32'hF000_0800;
    send_frame(fr); wait_done();
    check("f2_bin3_decay", got_level[3], 7);
    check("f2_bin5_sat", got_level[5], 15);
    check("f2_bin6", got_level[6], 2);

    fr = '{default: '0};
    send_frame(fr); wait_done();
    check("f3_bin3_decay", got_level[3], 6);
    check("f3_bin5_decay", got_level[5], 14);
    send_frame(fr); wait_done();
    check("f4_bin3_decay", got_level[3], 5);
    fr[3] = 32'h5000_0000;
    send_frame(fr); wait_done();
    check("f5_bin3_rise", got_level[3], 10);

    fr = '{default: '0}; fr[7] = 32'h3000_0000;
    send_frame(fr);
    wait_bin(7);
    bar_ready = 0;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_idx", int'(bar_idx), 7);
      check("stall_level", int'(bar_level), 6);
    end
    bar_ready = 1;
    wait_done();
    check("bp_latency", done_edge - cap_edge, 37);
    check("bp_count", got_cnt, 16);
    check("bp_bin7", got_level[7], 6);

    fr = '{default: '0}; fr[3] = 32'h4000_0000;
    send_frame(fr);
    d0 = done_cnt;
    for (int i = 0; i < 500 && done_cnt == d0; i++) begin
      for (int j = 0; j < 16; j++) fb[j] = rnd_bin();
      frame_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    frame_valid = 0;
    if (done_cnt == d0) check("ignore_timeout", 0, 1);
    check("ignore_bin3", got_level[3], 8);
    check("ignore_bin0", got_level[0], 0);

    d0 = done_cnt;
    frame_valid = 1;
    for (int i = 0; i < 3000 && done_cnt < d0 + 4; i++) begin
      for (int j = 0; j < 16; j++) fb[j] = rnd_bin();
      bar_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    frame_valid = 0;
    bar_ready = 1;
    check("random_frames", done_cnt - d0, 4);

    fr = '{default: '0}; fr[3] = 32'h7FFF_0000;
    send_frame(fr); wait_done();
    check("pre_rst_bin3", got_level[3], 15);
    send_frame(fr);
    wait_bin(9);
    reset_n = 0;
    #1;
    check("mid_rst_bar_valid", int'(bar_valid), 0);
    d0 = done_cnt;
    @(posedge clk); #1;
    reset_n = 1;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt, d0);
    fr = '{default: '0};
    send_frame(fr); wait_done();
    check("fresh_bin3", got_level[3], 0);
    check("fresh_count", got_cnt, 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
